bcd_display_driver: RTL
=======================

Name: bcd_display_driver

Overview:
Upstream stage of the 7-segment decoder. Converts a binary value to DIGITS packed BCD digits with a sequential double-dabble engine, using a start/busy/done handshake. Time-multiplexes the latched digits onto one 4-bit digit_out bus, which drives decoder_in, and drives active-low anode enables for a common-anode multi-digit display.

Parameters:
BIN_W, 14, width of the binary input; 14 bits covers 0..9999.
DIGITS, 4, number of BCD digits and anodes; legal range 1..8.
SCAN_DIV, 50000, clk cycles per digit slot; 1 kHz per digit at 50 MHz; minimum 2.
BLANK_LZ, 1, 1 blanks leading-zero digits; digit 0 is never blanked.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  conversion request, sampled only in IDLE.
bin_in  input  BIN_W  binary value, captured on the cycle start is accepted.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when the new digits are latched.
overflow  output  1  last captured value exceeded 10^DIGITS-1.
bcd_digits  output  4*DIGITS  latched digits; digit 0 is the least significant, at bits [3:0].
digit_out  output  4  BCD digit for the active slot; feeds the 7-segment decoder.
anode_n  output  DIGITS  active-low one-hot enable for the active slot.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0, all outputs and state are forced as follows:
  - busy=0, done=0, overflow=0.
  - bcd_digits=0, digit_out=0.
  - anode_n has only bit 0 low.
  - Scan index=0, prescaler=0, FSM=IDLE.
  - Reset mid-conversion abandons the conversion, and no done pulse is issued.
- FSM IDLE:
  - start=1 captures bin_in into a shift register, clears the BCD scratch, loads the iteration count=BIN_W, and moves to SHIFT.
  - If the captured value exceeds 10^DIGITS-1, an overflow flag is set internally.
- FSM SHIFT, one iteration per cycle:
  - Add 3 to every scratch nibble that is >=5.
  - Then shift {scratch, binary} left by 1.
  - Decrement the count; after BIN_W iterations, move to DONE.
- FSM DONE, one cycle:
  - bcd_digits is loaded from the scratch, or from all 9s when overflow is set.
  - The overflow output is updated.
  - done=1, then return to IDLE.
- Latency: with start sampled at edge 0, busy=1 from edge 1 through edge BIN_W+1. done=1 and bcd_digits update during the cycle after edge BIN_W+1. Total is BIN_W+2 cycles start-to-done.
- busy is 1 in SHIFT and DONE. start is ignored while busy and is not queued. start asserted in the same cycle done is high is also ignored; it must be held or re-asserted.
- Scratch width is 4*DIGITS plus any extra nibbles needed for BIN_W; all arithmetic is unsigned.
- The display keeps showing the previous bcd_digits throughout a conversion.
- overflow stays sticky until the next conversion completes.
- Scan prescaler:
  - Free-running counter 0..SCAN_DIV-1, independent of the FSM.
  - On its terminal count the scan index advances by 1 and wraps from DIGITS-1 to 0.
- Scan outputs:
  - digit_out = bcd_digits[index] and anode_n = ~(1<<index). Both are registered and change in the same cycle.
- Leading-zero blanking (BLANK_LZ=1):
  - Slot i>0 is blanked when it and every higher digit are 0.
  - A blanked slot keeps its time slot, but anode_n is driven all-ones; digit_out is still driven.
  - Blanking is evaluated on the latched bcd_digits.
- digit_out is always 0..9, so the downstream decoder never sees an undecoded code.

Decomposition:
- Package bcd_display_pkg:
  - FSM state enum: IDLE, SHIFT, DONE.
  - Constant MAX_VAL = 10^DIGITS-1, computed by a function.
  - Scratch-width function.
  - add3 nibble function.
- Sub-module display_scan_mux: prescaler, scan index, blanking and anode_n/digit_out registers. It takes bcd_digits as input.
- The top level holds the FSM and the double-dabble datapath.

Test Plan:
- Reset mid-conversion: assert rst_n=0 at cycle 5 of a conversion of 1234 -> done never pulses; bcd_digits=0; anode_n=4'b1110.
- Normal conversion: with BIN_W=14, start, bin_in=1234 -> busy high for 15 cycles; done pulse 16 cycles after start; bcd_digits=16'h1234; overflow=0.
- Boundary values:
  - bin_in=0 -> bcd_digits=16'h0000.
  - bin_in=9999 -> 16'h9999, overflow=0.
  - bin_in=10000 -> 16'h9999, overflow=1.
  - A following conversion of 5 clears overflow.
- Start while busy: pulse start during SHIFT with a different bin_in -> ignored; only one done pulse, carrying the first value.
- Scan with SCAN_DIV=4 and bcd_digits=16'h0042:
  - Slot 0: anode_n=1110, digit_out=2.
  - Slot 1: anode_n=1101, digit_out=4.
  - Slots 2 and 3 are blanked: anode_n=1111.
  - Each slot lasts 4 cycles; the index wraps 3->0.
- BLANK_LZ=0 with value 0 -> all four anodes scan in turn, digit_out=0 each slot; value 7 shows slots 0007.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// Shared types and elaboration-time helpers for the BCD display driver.
package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest value representable in the given number of decimal digits.
  function automatic longint unsigned max_val(input int unsigned digits);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

  // Scratch width in bits: enough nibbles for both the displayed digits and
  // the largest value the binary input can carry.
  function automatic int unsigned scratch_w(input int unsigned bin_w,
                                            input int unsigned digits);
    longint unsigned v;
    int unsigned     n;
    v = (bin_w >= 64) ? '1 : ((64'd1 << bin_w) - 64'd1);
    n = 0;
    while (v != 0) begin
      v = v / 10;
      n++;
    end
    if (n < digits) n = digits;
    if (n == 0) n = 1;
    return 4 * n;
  endfunction

  // Double-dabble correction: nibbles of 5 or more get 3 added before a shift.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bcd_display_driver_scan.sv
// Digit scan multiplexer: prescaler, slot index, leading-zero blanking and
// registered digit_out/anode_n for a common-anode display.
module display_scan_mux #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_digits,
  output logic [3:0]            digit_out,
  output logic [DIGITS-1:0]     anode_n
);

  localparam int unsigned PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PS_W-1:0]   ps;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic              tc;
  logic [DIGITS-1:0] blank;
  logic              zero_run;

  // Terminal count of the prescaler and the next slot index.
  always_comb begin
    tc      = (ps == PS_W'(SCAN_DIV - 1));
    idx_nxt = idx;
    if (tc) idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
  end

  // A slot above 0 is blank when it and every more significant digit are zero.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      int unsigned i;
      i        = DIGITS - 1 - k;
      zero_run = zero_run & (bcd_digits[4*i +: 4] == 4'd0);
      if (BLANK_LZ != 0 && i != 0) blank[i] = zero_run;
    end
  end

  // Outputs are registered from the next index so they move together with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps        <= '0;
      idx       <= '0;
      digit_out <= '0;
      anode_n   <= ~DIGITS'(1);
    end else begin
      ps        <= tc ? '0 : ps + PS_W'(1);
      idx       <= idx_nxt;
      digit_out <= bcd_digits[4*idx_nxt +: 4];
      anode_n   <= blank[idx_nxt] ? '1 : ~(DIGITS'(1) << idx_nxt);
    end
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD converter (sequential double dabble) with start/busy/done
// handshake, feeding a time-multiplexed common-anode digit scanner.
module bcd_display_driver
  import bcd_display_pkg::*;
#(
  parameter int unsigned BIN_W    = 14,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_digits,
  output logic [3:0]            digit_out,
  output logic [DIGITS-1:0]     anode_n
);

  localparam int unsigned     SW      = scratch_w(BIN_W, DIGITS);
  localparam int unsigned     NIB     = SW / 4;
  localparam int unsigned     CNT_W   = $clog2(BIN_W + 1);
  localparam longint unsigned MAX_VAL = max_val(DIGITS);

  state_t           state;
  logic [BIN_W-1:0] bin_sr;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    scratch_adj;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pend;

  assign busy = (state != IDLE);

  // Per-nibble add-3 correction applied ahead of each shift.
  always_comb begin
    scratch_adj = '0;
    for (int unsigned i = 0; i < NIB; i++)
      scratch_adj[4*i +: 4] = add3(scratch[4*i +: 4]);
  end

  // Conversion FSM and datapath; start is refused while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bin_sr     <= '0;
      scratch    <= '0;
      cnt        <= '0;
      ovf_pend   <= 1'b0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      bcd_digits <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            bin_sr   <= bin_in;
            scratch  <= '0;
            cnt      <= CNT_W'(BIN_W);
            ovf_pend <= (64'(bin_in) > MAX_VAL);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, bin_sr} <= {scratch_adj, bin_sr} << 1;
          cnt               <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          bcd_digits <= ovf_pend ? {DIGITS{4'h9}} : scratch[4*DIGITS-1:0];
          overflow   <= ovf_pend;
          done       <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  display_scan_mux #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .BLANK_LZ(BLANK_LZ)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .bcd_digits(bcd_digits),
    .digit_out (digit_out),
    .anode_n   (anode_n)
  );

endmodule
